// File: rtl/fxp_pkg.sv
// Shared fixed-point datapath types and width helpers.
package fxp_pkg;

  typedef enum logic {
    RND_TRUNC     = 1'b0,
    RND_HALF_AWAY = 1'b1
  } rnd_mode_e;

  // Accumulator width that holds acc_len full-precision products without overflow.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned acc_len);
    return 2 * data_w + $clog2(acc_len);
  endfunction

endpackage

// File: rtl/mac_acc_rnd_sat_if.sv
// Term input stream and result output stream of the MAC accumulator.
interface mac_acc_rnd_sat_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 36
) ();
  import fxp_pkg::*;

  logic signed [DATA_W-1:0] a_i;
  logic signed [DATA_W-1:0] x_i;
  logic signed [ACC_W-1:0]  b_i;
  logic                     valid_i;
  logic                     ready_o;
  logic                     flush_i;
  rnd_mode_e                rnd_mode_i;
  logic [DATA_W-1:0]        y_sat_o;
  logic [ACC_W-1:0]         y_ori_o;
  logic                     sat_o;
  logic                     valid_o;
  logic                     ready_i;

  modport master (
    output a_i, x_i, b_i, valid_i, flush_i, rnd_mode_i, ready_i,
    input  ready_o, y_sat_o, y_ori_o, sat_o, valid_o
  );

  modport slave (
    input  a_i, x_i, b_i, valid_i, flush_i, rnd_mode_i, ready_i,
    output ready_o, y_sat_o, y_ori_o, sat_o, valid_o
  );

endinterface

// File: rtl/fxp_round_sat.sv
// Rounds a Q(2F) accumulator to Q(F) and clamps it to DATA_W signed bits.
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int unsigned ACC_W  = 36,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 9
) (
  input  logic signed [ACC_W-1:0] acc,
  input  rnd_mode_e               rnd_mode,
  output logic [DATA_W-1:0]       y_sat_c,
  output logic                    sat_c
);

  localparam int unsigned RND_W = ACC_W - FRAC_W + 1;
  localparam int unsigned TOP_W = RND_W - DATA_W + 1;

  logic             carry;
  logic [RND_W-1:0] rnd;
  logic [TOP_W-1:0] top;

  // Carry from the dropped fraction, then clamp when the bits above the result sign disagree.
  always_comb begin
    carry   = 1'b0;
    rnd     = '0;
    top     = '0;
    y_sat_c = '0;
    sat_c   = 1'b0;
    if (rnd_mode == RND_HALF_AWAY) begin
      // Negative values need strictly more than half to move toward zero.
      carry = acc[ACC_W-1] ? (acc[FRAC_W-1] & (|acc[FRAC_W-2:0])) : acc[FRAC_W-1];
    end
    rnd   = {acc[ACC_W-1], acc[ACC_W-1:FRAC_W]} + RND_W'(carry);
    top   = rnd[RND_W-1:DATA_W-1];
    sat_c = ~(&top) & (|top);
    if (sat_c) begin
      y_sat_c = rnd[RND_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      y_sat_c = rnd[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/mac_acc_rnd_sat.sv
// Streaming signed MAC: bias plus ACC_LEN products, rounded and saturated per block.
module mac_acc_rnd_sat
  import fxp_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FRAC_W  = 9,
  parameter int unsigned ACC_LEN = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mac_acc_rnd_sat_if.slave bus
);

  localparam int unsigned ACC_W  = acc_width(DATA_W, ACC_LEN);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  logic                     stall;
  logic                     accept;
  logic [CNT_W-1:0]         cnt;
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] prod_c;

  logic                     s1_vld;
  logic                     s1_first;
  logic                     s1_last;
  logic signed [ACC_W-1:0]  s1_prod;
  logic signed [ACC_W-1:0]  s1_b;
  rnd_mode_e                s1_mode;

  logic                     s2_pend;
  rnd_mode_e                s2_mode;
  logic signed [ACC_W-1:0]  acc;

  logic [DATA_W-1:0]        y_sat_c;
  logic                     sat_c;

  // Backpressure freezes the whole pipeline; flush also refuses the current term.
  assign stall       = bus.valid_o & ~bus.ready_i;
  assign bus.ready_o = ~stall & ~bus.flush_i;
  assign accept      = bus.valid_i & bus.ready_o;

  // Full-precision signed product.
  assign a_ext  = {{DATA_W{bus.a_i[DATA_W-1]}}, bus.a_i};
  assign x_ext  = {{DATA_W{bus.x_i[DATA_W-1]}}, bus.x_i};
  assign prod_c = a_ext * x_ext;

  // Stage 1: product register, block position flags and term counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
      s1_b     <= '0;
      s1_mode  <= RND_TRUNC;
    end else if (bus.flush_i) begin
      cnt    <= '0;
      s1_vld <= 1'b0;
    end else if (!stall) begin
      s1_vld <= accept;
      if (accept) begin
        s1_prod  <= ACC_W'(prod_c);
        s1_b     <= bus.b_i;
        s1_mode  <= bus.rnd_mode_i;
        s1_first <= (cnt == '0);
        s1_last  <= (cnt == CNT_LAST);
        cnt      <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  // Stage 2: accumulator, restarted from the bias on the first term of a block.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc     <= '0;
      s2_pend <= 1'b0;
      s2_mode <= RND_TRUNC;
    end else if (!stall) begin
      s2_pend <= s1_vld & s1_last;
      if (s1_vld) begin
        acc     <= (s1_first ? s1_b : acc) + s1_prod;
        s2_mode <= s1_mode;
      end
    end
  end

  fxp_round_sat #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_round_sat (
    .acc     (acc),
    .rnd_mode(s2_mode),
    .y_sat_c (y_sat_c),
    .sat_c   (sat_c)
  );

  // Output register: loads a finished block, otherwise drops valid once consumed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.y_ori_o <= '0;
      bus.y_sat_o <= '0;
      bus.sat_o   <= 1'b0;
      bus.valid_o <= 1'b0;
    end else if (!stall && s2_pend) begin
      bus.y_ori_o <= acc;
      bus.y_sat_o <= y_sat_c;
      bus.sat_o   <= sat_c;
      bus.valid_o <= 1'b1;
    end else if (bus.ready_i) begin
      bus.valid_o <= 1'b0;
    end
  end

endmodule
